// File: rtl/ro_adc_packer_if.sv
// Output word stream of the ADC packer.
// master drives data/valid, slave drives ready.
interface ro_adc_packer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ro_adc_packer.sv
// Packs ADC samples two per word, adds a row trailer, FWFT FIFO out.
// In: CLK rst frame_start NUM_ROW NUM_SAMP dat_valid adc_data; Out: dst stream, status.
module ro_adc_packer #(
  parameter int         ADC_W      = 12,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] TAG        = 8'hA5,
  localparam int        AW         = $clog2(FIFO_DEPTH),
  localparam int        LW         = AW + 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [31:0]       NUM_ROW,
  input  logic [31:0]       NUM_SAMP,
  input  logic              dat_valid,
  input  logic [ADC_W-1:0]  adc_data,
  ro_adc_packer_if.master   dst,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              stray,
  output logic [LW-1:0]     fifo_level
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    TRAIL
  } state_t;

  state_t      state, nxt;
  logic [31:0] num_row, num_samp;
  logic [31:0] row_cnt, samp_cnt;
  logic        phase;
  logic [15:0] low;
  logic [7:0]  frame_cnt;

  logic [15:0] s16;
  logic        last_samp, last_row;
  logic        wr_en;
  logic [31:0] wr_data;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, pop, push;

  assign s16       = 16'(adc_data);
  assign last_samp = samp_cnt == num_samp - 32'd1;
  assign last_row  = row_cnt == num_row - 32'd1;
  assign busy      = state != IDLE;

  always_comb begin
    nxt     = state;
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state)
      IDLE: begin
        if (frame_start) nxt = ACTIVE;
      end
      ACTIVE: begin
        if (dat_valid) begin
          if (phase) begin
            wr_en   = 1'b1;
            wr_data = {s16, low};
          end else if (last_samp) begin
            // odd sample count: pad the final half-word
            wr_en   = 1'b1;
            wr_data = {16'h0000, s16};
          end
          if (last_samp) nxt = TRAIL;
        end
      end
      TRAIL: begin
        wr_en   = 1'b1;
        wr_data = {TAG, frame_cnt, row_cnt[15:0]};
        nxt     = last_row ? IDLE : ACTIVE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      num_row    <= '0;
      num_samp   <= '0;
      row_cnt    <= '0;
      samp_cnt   <= '0;
      phase      <= 1'b0;
      low        <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      stray      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            num_row  <= NUM_ROW;
            num_samp <= NUM_SAMP;
            row_cnt  <= '0;
            samp_cnt <= '0;
            phase    <= 1'b0;
            stray    <= 1'b0;
          end
          if (dat_valid) stray <= 1'b1;
        end
        ACTIVE: begin
          if (dat_valid) begin
            if (last_samp) begin
              samp_cnt <= '0;
              phase    <= 1'b0;
            end else begin
              samp_cnt <= samp_cnt + 32'd1;
              phase    <= ~phase;
              if (!phase) low <= s16;
            end
          end
        end
        TRAIL: begin
          if (last_row) begin
            frame_cnt  <= frame_cnt + 8'd1;
            frame_done <= 1'b1;
            if (dat_valid) stray <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 32'd1;
            // a sample here opens the next row
            if (dat_valid) begin
              low      <= s16;
              phase    <= 1'b1;
              samp_cnt <= 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_level    = wr_ptr - rd_ptr;
  assign full          = fifo_level == LW'(FIFO_DEPTH);
  assign empty         = fifo_level == '0;
  assign pop           = !empty && dst.out_ready;
  assign push          = wr_en && (!full || pop);
  assign dst.out_valid = !empty;
  assign dst.out_data  = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (state == IDLE && frame_start) overflow <= 1'b0;
      else if (wr_en && !push)          overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ro_adc_packer.sv
// Scoreboard bench for ro_adc_packer.
// Directed frames; monitor pops expected words on each handshake.
module tb_ro_adc_packer;
  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] NUM_ROW = '0;
  logic [31:0] NUM_SAMP = '0;
  logic        dat_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic        busy, frame_done, overflow, stray;
  logic [3:0]  fifo_level;

  ro_adc_packer_if ifc ();

  ro_adc_packer dut (
    .CLK         (CLK),
    .rst         (rst),
    .frame_start (frame_start),
    .NUM_ROW     (NUM_ROW),
    .NUM_SAMP    (NUM_SAMP),
    .dat_valid   (dat_valid),
    .adc_data    (adc_data),
    .dst         (ifc.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .stray       (stray),
    .fifo_level  (fifo_level)
  );

  always #5 CLK = ~CLK;

  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always @(negedge CLK) begin
    if (!rst && frame_done) done_cnt++;
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected got=%08h want=none", ifc.out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ifc.out_data !== e) begin
          errors++;
          $display("FAIL word got=%08h want=%08h", ifc.out_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    done_cnt = 0;
  endtask

  task automatic start(input int rows, input int samps);
    frame_start = 1'b1;
    NUM_ROW = rows;
    NUM_SAMP = samps;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [11:0] s);
    dat_valid = 1'b1;
    adc_data = s;
    tick();
    dat_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || ifc.out_valid) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain_timeout got=%0d want=0 words left", nm, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    ifc.out_ready = 1'b1;
    tick();
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(ifc.out_valid), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_data", ifc.out_data, 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_stray", 32'(stray), 0);

    // continuous stream, 2 rows x 4 samples
    exp_q.push_back(32'h00020001);
    exp_q.push_back(32'h00040003);
    exp_q.push_back(32'hA5000000);
    exp_q.push_back(32'h00060005);
    exp_q.push_back(32'h00080007);
    exp_q.push_back(32'hA5000001);
    start(2, 4);
    for (int i = 1; i <= 8; i++) send(12'(i));
    wait_empty("stream");
    repeat (3) tick();
    chk("stream_done_cnt", done_cnt, 1);
    chk("stream_busy", 32'(busy), 0);

    // odd sample count with latency probe
    do_reset();
    exp_q.push_back(32'h000B000A);
    exp_q.push_back(32'h0000000C);
    exp_q.push_back(32'hA5000000);
    start(1, 3);
    send(12'hA);
    chk("odd_no_word_yet", 32'(ifc.out_valid), 0);
    send(12'hB);
    chk("odd_latency_valid", 32'(ifc.out_valid), 1);
    send(12'hC);
    wait_empty("odd");

    // back-to-back rows, sample lands in TRAIL
    do_reset();
    exp_q.push_back(32'h00220011);
    exp_q.push_back(32'hA5000000);
    exp_q.push_back(32'h00440033);
    exp_q.push_back(32'hA5000001);
    start(2, 2);
    send(12'h11);
    send(12'h22);
    send(12'h33);
    send(12'h44);
    wait_empty("b2b");
    chk("b2b_stray", 32'(stray), 0);

    // backpressure and overflow
    do_reset();
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      exp_q.push_back({4'h0, 12'(2*i+2), 4'h0, 12'(2*i+1)});
    start(1, 20);
    for (int i = 1; i <= 20; i++) send(12'(i));
    repeat (2) tick();
    chk("bp_level", 32'(fifo_level), 8);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_busy", 32'(busy), 0);
    ifc.out_ready = 1'b1;
    wait_empty("bp");
    chk("bp_ovf_sticky", 32'(overflow), 1);
    start(1, 2);
    chk("bp_ovf_cleared", 32'(overflow), 0);
    exp_q.push_back(32'h00020001);
    exp_q.push_back(32'hA5010000);
    send(12'h1);
    send(12'h2);
    wait_empty("bp_after");

    // stray and mid-row reset
    do_reset();
    send(12'h7);
    chk("stray_set", 32'(stray), 1);
    chk("stray_idle_valid", 32'(ifc.out_valid), 0);
    exp_q.push_back(32'h00020001);
    exp_q.push_back(32'hA5000000);
    start(1, 2);
    chk("stray_cleared", 32'(stray), 0);
    send(12'h1);
    send(12'h2);
    wait_empty("pre_rst");
    ifc.out_ready = 1'b0;
    start(1, 4);
    send(12'h1);
    send(12'h2);
    send(12'h3);
    chk("mid_level", 32'(fifo_level), 1);
    chk("mid_busy", 32'(busy), 1);
    do_reset();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(ifc.out_valid), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    ifc.out_ready = 1'b1;
    exp_q.push_back(32'h00060005);
    exp_q.push_back(32'hA5000000);
    start(1, 2);
    send(12'h5);
    send(12'h6);
    wait_empty("post_rst");

    // frame counter wrap over 257 frames
    do_reset();
    for (int i = 0; i < 257; i++) begin
      exp_q.push_back({4'h0, 12'(i+1), 4'h0, 12'(i)});
      if (i == 255)      exp_q.push_back(32'hA5FF0000);
      else if (i == 256) exp_q.push_back(32'hA5000000);
      else               exp_q.push_back({8'hA5, 8'(i), 16'h0000});
      start(1, 2);
      send(12'(i));
      send(12'(i+1));
      tick();
    end
    wait_empty("wrap");
    chk("wrap_done_cnt", done_cnt, 257);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
